// File: rtl/pwm_capture.sv
// Servo PWM decoder: measures the high time of pwm_in and maps it onto position 0..125.
// Latency: result strobes 24 cycles after the synchronized falling edge (restoring divide, 23 steps).
// Backpressure: none; a falling edge that arrives while the divider is busy is dropped.
module pwm_capture #(
   parameter int unsigned PERIOD_CYCLES = 1_000_000,
   parameter int unsigned MIN_PULSE     = 75_000,
   parameter int unsigned MAX_PULSE     = 130_000,
   parameter int unsigned LOST_CYCLES   = 2_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pwm_in,
   output logic [19:0] pulse_width,
   output logic [7:0]  position,
   output logic        valid,
   output logic        range_err,
   output logic        lost
);

   localparam int unsigned WW = 20;
   localparam int unsigned NW = 23;
   localparam int unsigned LW = $clog2(LOST_CYCLES + 1);

   localparam logic [WW-1:0] MIN_W   = WW'(MIN_PULSE);
   localparam logic [WW-1:0] MAX_W   = WW'(MAX_PULSE);
   localparam logic [WW-1:0] DEN_W   = WW'(MAX_PULSE - MIN_PULSE);
   localparam logic [WW-1:0] CNT_MAX = '1;
   localparam logic [LW-1:0] LOST_W  = LW'(LOST_CYCLES);
   localparam logic [4:0]    LAST_IT = 5'(NW - 1);

   // The pulse window must fit inside a frame and a frame inside the loss timeout.
   localparam bit PARAMS_OK = (MIN_PULSE < MAX_PULSE) && (MAX_PULSE < PERIOD_CYCLES) &&
                              (PERIOD_CYCLES < LOST_CYCLES);

   typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, HIGH} meas_state_t;
   typedef enum logic [1:0] {IDLE, DIVIDE, DONE}        div_state_t;

   meas_state_t    meas_state, meas_next;
   div_state_t     div_state, div_next;

   logic           sync1, s, s_prev;
   logic           rise, fall;
   logic           meas_load, meas_inc, meas_end;
   logic [WW-1:0]  hi_cnt;
   logic [LW-1:0]  lost_cnt;

   logic           div_start, div_step, div_last;
   logic [WW-1:0]  w_q;
   logic           err_q, sat_q;
   logic [NW-1:0]  quo;
   logic [WW-1:0]  rem, rem_next;
   logic [WW:0]    rem_shift;
   logic           q_bit;
   logic [4:0]     iter;

   logic           below, above;
   logic [WW-1:0]  diff;
   logic [NW-1:0]  num_load;

   param_sanity: assert property (@(posedge clk) PARAMS_OK);

   // Two-flop synchronizer plus history flop; all preset high so a line already high is no edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b1;
         s      <= 1'b1;
         s_prev <= 1'b1;
      end else begin
         sync1  <= pwm_in;
         s      <= sync1;
         s_prev <= s;
      end
   end

   assign rise = s & ~s_prev;
   assign fall = ~s & s_prev;

   // Measurement FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) meas_state <= WAIT_LOW;
      else        meas_state <= meas_next;
   end

   // Measurement FSM next state: only a full low-high-low sequence is measured.
   always_comb begin
      meas_next = meas_state;
      case (meas_state)
         WAIT_LOW:  if (!s)   meas_next = WAIT_RISE;
         WAIT_RISE: if (rise) meas_next = HIGH;
         HIGH:      if (fall) meas_next = WAIT_RISE;
         default:             meas_next = WAIT_LOW;
      endcase
   end

   // Measurement FSM outputs: counter load/increment and end-of-pulse event.
   always_comb begin
      meas_load = (meas_state == WAIT_RISE) && rise;
      meas_inc  = (meas_state == HIGH) && s;
      meas_end  = (meas_state == HIGH) && fall;
   end

   // High-time counter: starts at 1 in the rise cycle, saturates instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          hi_cnt <= '0;
      else if (meas_load)                  hi_cnt <= WW'(1);
      else if (meas_inc && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + WW'(1);
   end

   // Loss timer: counts cycles since the last rise, parks at the timeout value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 lost_cnt <= '0;
      else if (rise)              lost_cnt <= LW'(1);
      else if (lost_cnt != LOST_W) lost_cnt <= lost_cnt + LW'(1);
   end

   assign lost = (lost_cnt == LOST_W);

   // Clamp the measured width and form the 23-bit dividend (zero when out of range).
   always_comb begin
      below    = (hi_cnt < MIN_W);
      above    = (hi_cnt > MAX_W);
      diff     = hi_cnt - MIN_W;
      num_load = (below || above) ? '0 : NW'(diff) * NW'(125);
   end

   // Divider FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) div_state <= IDLE;
      else        div_state <= div_next;
   end

   // Divider FSM next state: accept only when idle, 23 steps, one result cycle.
   always_comb begin
      div_next = div_state;
      case (div_state)
         IDLE:    if (meas_end)        div_next = DIVIDE;
         DIVIDE:  if (iter == LAST_IT) div_next = DONE;
         DONE:                         div_next = IDLE;
         default:                      div_next = IDLE;
      endcase
   end

   // Divider FSM outputs and the strobes seen by the outside world.
   always_comb begin
      div_start = (div_state == IDLE) && meas_end;
      div_step  = (div_state == DIVIDE);
      div_last  = div_step && (iter == LAST_IT);
      valid     = (div_state == DONE);
      range_err = (div_state == DONE) && err_q;
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_shift = {rem, quo[NW-1]};
      q_bit     = (rem_shift >= {1'b0, DEN_W});
      rem_next  = q_bit ? WW'(rem_shift - {1'b0, DEN_W}) : rem_shift[WW-1:0];
   end

   // Divider datapath: dividend shifts out the top while quotient bits enter the bottom.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q   <= '0;
         err_q <= 1'b0;
         sat_q <= 1'b0;
         quo   <= '0;
         rem   <= '0;
         iter  <= '0;
      end else if (div_start) begin
         w_q   <= hi_cnt;
         err_q <= below | above;
         sat_q <= above;
         quo   <= num_load;
         rem   <= '0;
         iter  <= '0;
      end else if (div_step) begin
         quo   <= {quo[NW-2:0], q_bit};
         rem   <= rem_next;
         iter  <= iter + 5'd1;
      end
   end

   // Result registers change only on the final divide step, so they hold between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_width <= '0;
         position    <= '0;
      end else if (div_last) begin
         pulse_width <= w_q;
         position    <= sat_q ? 8'd125 : {quo[6:0], q_bit};
      end
   end

endmodule
